// File: rtl/pipe_rca.sv
// Pipelined ripple-carry adder/subtractor with a valid/ready handshake.
// The operand is split into SEG_W-bit segments; each stage ripples one
// segment and hands its carry to the next stage through a register.
// Unprocessed upper operand bits travel forward with the beat, and the
// already-computed lower sum bits are delayed so they align at the output.
// Latency is STAGES = WIDTH/SEG_W cycles, throughput one beat per cycle.
module pipe_rca #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c,
  output logic             out_ovf
);

  localparam int STAGES = WIDTH / SEG_W;

  // One segment of ripple addition: {carry_out, sum} of a + b + cin.
  function automatic logic [SEG_W:0] seg_add(input logic [SEG_W-1:0] a,
                                             input logic [SEG_W-1:0] b,
                                             input logic             cin);
    seg_add = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
  endfunction

  // Signed overflow: carry into the MSB (recovered as a^b^s at the MSB)
  // differs from the carry out of the MSB.
  function automatic logic ovf_flag(input logic a_msb, input logic b_msb,
                                    input logic s_msb, input logic c_out);
    ovf_flag = a_msb ^ b_msb ^ s_msb ^ c_out;
  endfunction

  // The whole pipe moves together; it only freezes when a result is
  // waiting and downstream refuses it. Bubbles are held, never collapsed.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int RW = WIDTH - k * SEG_W;  // operand bits not yet consumed
    localparam int LW = (k + 1) * SEG_W;    // sum bits known after this stage

    logic [RW-1:0]  a_cur;
    logic [RW-1:0]  b_cur;
    logic           c_cur;
    logic           vld_cur;
    logic [SEG_W:0] seg;
    logic [LW-1:0]  s_cur;

    if (k == 0) begin : g_in
      // Stage 0 works straight off the input port; subtract inverts B and
      // turns the carry-in into a borrow-in.
      assign a_cur   = in_a;
      assign b_cur   = in_sub ? ~in_b : in_b;
      assign c_cur   = in_sub ^ in_c;
      assign vld_cur = in_valid;
      assign s_cur   = seg[SEG_W-1:0];
    end else begin : g_reg
      logic [RW-1:0]       a_p;
      logic [RW-1:0]       b_p;
      logic [k*SEG_W-1:0]  s_p;
      logic                c_p;
      logic                vld_p;

      // Stage boundary k-1 -> k: valid bit, cleared by reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p <= 1'b0;
        end else if (advance) begin
          vld_p <= g_stg[k-1].vld_cur;
        end
      end

      // Stage boundary k-1 -> k: carry, remaining operand bits, lower sum.
      always_ff @(posedge clk) begin
        if (advance) begin
          a_p <= g_stg[k-1].a_cur[RW+SEG_W-1:SEG_W];
          b_p <= g_stg[k-1].b_cur[RW+SEG_W-1:SEG_W];
          s_p <= g_stg[k-1].s_cur;
          c_p <= g_stg[k-1].seg[SEG_W];
        end
      end

      assign a_cur   = a_p;
      assign b_cur   = b_p;
      assign c_cur   = c_p;
      assign vld_cur = vld_p;
      assign s_cur   = {seg[SEG_W-1:0], s_p};
    end

    assign seg = seg_add(a_cur[SEG_W-1:0], b_cur[SEG_W-1:0], c_cur);
  end

  // Final stage boundary: result registers, all cleared by reset so the
  // port reads zero until the first beat arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_s     <= '0;
      out_c     <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (advance) begin
      out_valid <= g_stg[STAGES-1].vld_cur;
      out_s     <= g_stg[STAGES-1].s_cur;
      out_c     <= g_stg[STAGES-1].seg[SEG_W];
      out_ovf   <= ovf_flag(g_stg[STAGES-1].a_cur[SEG_W-1],
                            g_stg[STAGES-1].b_cur[SEG_W-1],
                            g_stg[STAGES-1].seg[SEG_W-1],
                            g_stg[STAGES-1].seg[SEG_W]);
    end
  end

endmodule
